range_update_engine: RTL and testbench

- Binary arithmetic-decoding range/code update stage of the LiDAR entropy decoder range calculator.
- Sits directly downstream of the probability lookup stage and consumes its 16-bit symbol probability.
- Splits the current range by that probability, decides the decoded bin, and updates range/code.
- Renormalises by pulling bitstream bits one per cycle, then hands the bin to the symbol reassembly logic.

---
 rtl/range_update_engine_pkg.sv | 40 ++++
 rtl/range_update_engine_if.sv | 39 +++
 rtl/range_update_engine_split_mul.sv | 41 ++++
 rtl/range_update_engine.sv | 160 ++++++++++++++++
 tb/tb_range_update_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/range_update_engine_pkg.sv
// -----------------------------------------------------------------------------
// entropy_dec_pkg
// Shared definitions for the LiDAR entropy decoder range calculator:
// the range/code datapath width, reset and renormalisation constants,
// the range-update FSM state encoding and the split clamp helper.
// -----------------------------------------------------------------------------
package entropy_dec_pkg;

  localparam int              RANGE_W    = 16;
  localparam logic [15:0]     INIT_RANGE = 16'hFFFF;
  localparam int              RENORM_MSB = 15;
  localparam int              INIT_BITS  = 16;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    SPLIT  = 3'd2,
    DECIDE = 3'd3,
    RENORM = 3'd4,
    OUT    = 3'd5
  } state_e;

  // Keeps both sub-intervals non-empty: a zero split would make bin 0
  // undecodable and a split equal to range would make bin 1 undecodable.
  function automatic logic [RANGE_W-1:0] clamp_split(
    input logic [RANGE_W-1:0] split,
    input logic [RANGE_W-1:0] range
  );
    logic [RANGE_W-1:0] res;
    if (split == {RANGE_W{1'b0}}) begin
      res = {{(RANGE_W-1){1'b0}}, 1'b1};
    end else if (split >= range) begin
      res = range - {{(RANGE_W-1){1'b0}}, 1'b1};
    end else begin
      res = split;
    end
    return res;
  endfunction

endpackage

// File: rtl/range_update_engine_if.sv
// -----------------------------------------------------------------------------
// range_update_engine_if
// Groups the handshake/bus signals of the range update engine.
//   start                     : restart pulse for a new slice
//   symbol_prob/prob_valid/prob_ready : probability stream from lookup stage
//   bit_in/bit_valid/bit_ready        : bitstream, MSB-first, one bit per beat
//   bin_out/bin_valid/bin_ready       : decoded bin stream to reassembly
//   range_out, bin_count              : monitor outputs
// master = upstream/downstream environment, slave = the engine.
// -----------------------------------------------------------------------------
interface range_update_engine_if #(
  parameter int RANGE_W = 16,
  parameter int CNT_W   = 16
);

  logic               start;
  logic [RANGE_W-1:0] symbol_prob;
  logic               prob_valid;
  logic               prob_ready;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic               bin_out;
  logic               bin_valid;
  logic               bin_ready;
  logic [RANGE_W-1:0] range_out;
  logic [CNT_W-1:0]   bin_count;

  modport master (
    output start, symbol_prob, prob_valid, bit_in, bit_valid, bin_ready,
    input  prob_ready, bit_ready, bin_out, bin_valid, range_out, bin_count
  );

  modport slave (
    input  start, symbol_prob, prob_valid, bit_in, bit_valid, bin_ready,
    output prob_ready, bit_ready, bin_out, bin_valid, range_out, bin_count
  );

endinterface

// File: rtl/range_update_engine_split_mul.sv
// -----------------------------------------------------------------------------
// range_split_mul
// Registered 16x16 unsigned multiply of range by a Q0.16 probability; keeps
// the upper half of the product and clamps it into [1, range-1].
//   clk, reset : clock, async active-high reset
//   en_i       : capture a new split this cycle
//   range_i    : current range
//   prob_i     : probability of bin 0 (Q0.16)
//   split_o    : clamped split, valid the cycle after en_i
// -----------------------------------------------------------------------------
module range_split_mul
  import entropy_dec_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [RANGE_W-1:0] range_i,
  input  logic [RANGE_W-1:0] prob_i,
  output logic [RANGE_W-1:0] split_o
);

  logic [2*RANGE_W-1:0] prod_d;
  logic [RANGE_W-1:0]   split_q;

  // Full-width product; zero-extend so the multiply is done at 32 bits.
  always_comb begin
    prod_d = {{RANGE_W{1'b0}}, range_i} * {{RANGE_W{1'b0}}, prob_i};
  end

  // Capture the clamped upper half when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_q <= {RANGE_W{1'b0}};
    end else if (en_i) begin
      split_q <= clamp_split(prod_d[2*RANGE_W-1:RANGE_W], range_i);
    end
  end

  assign split_o = split_q;

endmodule

// File: rtl/range_update_engine.sv
// -----------------------------------------------------------------------------
// range_update_engine
// Binary arithmetic-decoding range/code update stage. Loads a 16-bit code
// window, then per probability: splits the range, decides the bin, updates
// range/code, renormalises one bitstream bit per cycle and presents the bin.
//   clk, reset : clock, async active-high reset
//   bus        : range_update_engine_if.slave (see interface for signals)
// -----------------------------------------------------------------------------
module range_update_engine
  import entropy_dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  range_update_engine_if.slave bus
);

  state_e             state_q;
  logic [RANGE_W-1:0] range_q;
  logic [RANGE_W-1:0] code_q;
  logic [RANGE_W-1:0] p_q;
  logic [4:0]         init_cnt_q;
  logic [CNT_W-1:0]   bin_count_q;
  logic               prob_ready_q;
  logic               bit_ready_q;
  logic               bin_valid_q;
  logic               bin_out_q;

  logic [RANGE_W-1:0] split_d;
  logic [RANGE_W-1:0] code_shift_d;
  logic [RANGE_W-1:0] dec_range_d;
  logic [RANGE_W-1:0] dec_code_d;
  logic               dec_bin_d;
  logic               bit_take_d;

  range_split_mul u_split_mul (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == SPLIT),
    .range_i (range_q),
    .prob_i  (p_q),
    .split_o (split_d)
  );

  // Interval decision and bit-shift helpers for the FSM.
  always_comb begin
    code_shift_d = {code_q[RANGE_W-2:0], bus.bit_in};
    bit_take_d   = bit_ready_q & bus.bit_valid;
    if (code_q < split_d) begin
      dec_bin_d   = 1'b0;
      dec_range_d = split_d;
      dec_code_d  = code_q;
    end else begin
      dec_bin_d   = 1'b1;
      dec_range_d = range_q - split_d;
      dec_code_d  = code_q - split_d;
    end
  end

  // Range/code FSM; handshake outputs are registered alongside the state
  // so each ready/valid reflects the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      range_q      <= INIT_RANGE;
      code_q       <= {RANGE_W{1'b0}};
      p_q          <= {RANGE_W{1'b0}};
      init_cnt_q   <= 5'd0;
      bin_count_q  <= {CNT_W{1'b0}};
      prob_ready_q <= 1'b0;
      bit_ready_q  <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_out_q    <= 1'b0;
    end else if (bus.start) begin
      state_q      <= INIT;
      range_q      <= INIT_RANGE;
      code_q       <= {RANGE_W{1'b0}};
      init_cnt_q   <= 5'd0;
      bin_count_q  <= {CNT_W{1'b0}};
      prob_ready_q <= 1'b0;
      bit_ready_q  <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_out_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (bit_take_d) begin
            code_q <= code_shift_d;
            if (init_cnt_q == 5'(INIT_BITS - 1)) begin
              init_cnt_q   <= 5'd0;
              state_q      <= IDLE;
              bit_ready_q  <= 1'b0;
              prob_ready_q <= 1'b1;
            end else begin
              init_cnt_q  <= init_cnt_q + 5'd1;
              bit_ready_q <= 1'b1;
            end
          end else begin
            bit_ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (prob_ready_q && bus.prob_valid) begin
            p_q          <= bus.symbol_prob;
            prob_ready_q <= 1'b0;
            state_q      <= SPLIT;
          end
        end
        SPLIT: begin
          state_q <= DECIDE;
        end
        DECIDE: begin
          range_q     <= dec_range_d;
          code_q      <= dec_code_d;
          bin_out_q   <= dec_bin_d;
          bit_ready_q <= ~dec_range_d[RENORM_MSB];
          state_q     <= RENORM;
        end
        RENORM: begin
          if (range_q[RENORM_MSB]) begin
            bit_ready_q <= 1'b0;
            bin_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (bit_take_d) begin
            range_q     <= {range_q[RANGE_W-2:0], 1'b0};
            code_q      <= code_shift_d;
            // Drop ready once the shifted range becomes normalised.
            bit_ready_q <= ~range_q[RENORM_MSB-1];
          end
        end
        OUT: begin
          if (bus.bin_ready) begin
            bin_count_q  <= bin_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            bin_valid_q  <= 1'b0;
            prob_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= INIT;
          range_q      <= INIT_RANGE;
          code_q       <= {RANGE_W{1'b0}};
          init_cnt_q   <= 5'd0;
          prob_ready_q <= 1'b0;
          bit_ready_q  <= 1'b0;
          bin_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prob_ready = prob_ready_q;
  assign bus.bit_ready  = bit_ready_q;
  assign bus.bin_valid  = bin_valid_q;
  assign bus.bin_out    = bin_out_q;
  assign bus.range_out  = range_q;
  assign bus.bin_count  = bin_count_q;

endmodule

// File: tb/tb_range_update_engine.sv
module tb_range_update_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  range_update_engine_if #(.RANGE_W(16), .CNT_W(16)) bus();

  range_update_engine #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  bit          mon_en   = 1'b0;
  int          last_edges;
  logic [15:0] m_range, m_code, m_count;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Handshake exclusivity and normalised range whenever idle or presenting.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("excl", 32'(($countones({bus.prob_ready, bus.bit_ready, bus.bin_valid}) <= 1)), 32'd1);
      if (bus.prob_ready || bus.bin_valid) chk("range_norm", 32'(bus.range_out[15]), 32'd1);
    end
  end

  task automatic model_reset();
    m_range = 16'hFFFF;
    m_code  = 16'h0000;
    m_count = 16'h0000;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    model_reset();
    chk("start_bin_valid", 32'(bus.bin_valid), 32'd0);
    chk("start_count", 32'(bus.bin_count), 32'd0);
    chk("start_range", 32'(bus.range_out), 32'hFFFF);
    chk("start_prob_ready", 32'(bus.prob_ready), 32'd0);
  endtask

  task automatic feed_init(input logic [15:0] v);
    int guard;
    for (int i = 15; i >= 0; i--) begin
      guard = 0;
      while (!bus.bit_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!bus.bit_ready) chk("init_bit_ready_timeout", 32'(bus.bit_ready), 32'd1);
      bus.bit_in    = v[i];
      bus.bit_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bit_valid = 1'b0;
    end
    m_code  = v;
    m_range = 16'hFFFF;
    chk("init_no_bin", 32'(bus.bin_valid), 32'd0);
  endtask

  // One probability transaction against the arithmetic-decoding reference.
  task automatic txn(input logic [15:0] prob, input int hold, input int stall_at,
                     input int stall_len, input bit accept, input int abort_at);
    logic [31:0] prod;
    logic [15:0] split, tmp, frozen;
    logic        exp_bin, b;
    int          exp_bits, edges, consumed, stalls, guard;
    bit          aborted;
    prod  = {16'h0, m_range} * {16'h0, prob};
    split = prod[31:16];
    if (split == 16'h0) split = 16'h1;
    else if (split >= m_range) split = m_range - 16'h1;
    if (m_code < split) begin
      exp_bin = 1'b0;
      m_range = split;
    end else begin
      exp_bin = 1'b1;
      m_code  = m_code - split;
      m_range = m_range - split;
    end
    exp_bits = 0;
    tmp = m_range;
    while (!tmp[15]) begin
      tmp = tmp << 1;
      exp_bits++;
    end

    guard = 0;
    while (!bus.prob_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("prob_ready", 32'(bus.prob_ready), 32'd1);
    bus.symbol_prob = prob;
    bus.prob_valid  = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.prob_valid  = 1'b0;
    bus.symbol_prob = 16'($urandom);

    consumed = 0;
    stalls   = 0;
    aborted  = 1'b0;
    guard    = 0;
    while (!bus.bin_valid && guard < 100) begin
      if (abort_at >= 0 && consumed == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (bus.bit_ready) begin
        if (consumed == stall_at && stalls < stall_len) begin
          frozen = bus.range_out;
          stalls++;
          @(posedge clk);
          @(negedge clk);
          chk("stall_frozen", 32'(bus.range_out), 32'(frozen));
        end else begin
          b = 1'($urandom_range(0, 1));
          bus.bit_in    = b;
          bus.bit_valid = 1'b1;
          consumed++;
          m_range = m_range << 1;
          m_code  = {m_code[14:0], b};
          @(posedge clk);
          @(negedge clk);
          bus.bit_valid = 1'b0;
        end
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      edges++;
      guard++;
    end
    if (aborted) return;
    last_edges = edges;
    chk("bin_valid", 32'(bus.bin_valid), 32'd1);
    chk("latency", 32'(edges), 32'(4 + exp_bits + stalls));
    chk("renorm_bits", 32'(consumed), 32'(exp_bits));
    chk("bin_out", 32'(bus.bin_out), 32'(exp_bin));
    chk("range", 32'(bus.range_out), 32'(m_range));

    for (int h = 0; h < hold; h++) begin
      bus.bin_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(bus.bin_valid), 32'd1);
      chk("hold_bin", 32'(bus.bin_out), 32'(exp_bin));
      chk("hold_pready", 32'(bus.prob_ready), 32'd0);
      chk("hold_bready", 32'(bus.bit_ready), 32'd0);
      chk("hold_count", 32'(bus.bin_count), 32'(m_count));
    end
    if (accept) begin
      bus.bin_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bin_ready = 1'b0;
      m_count = m_count + 16'h1;
      chk("count", 32'(bus.bin_count), 32'(m_count));
      chk("valid_drop", 32'(bus.bin_valid), 32'd0);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.symbol_prob = 16'h0;
    bus.prob_valid  = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.bin_ready   = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_prob_ready", 32'(bus.prob_ready), 32'd0);
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("rst_bin_valid", 32'(bus.bin_valid), 32'd0);
    chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
    chk("rst_count", 32'(bus.bin_count), 32'd0);
    chk("rst_range", 32'(bus.range_out), 32'hFFFF);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Bin 0 with a single renormalisation bit.
    do_start();
    feed_init(16'h4000);
    txn(16'h8000, 0, -1, 0, 1'b1, -1);
    chk("t1_bin", 32'(bus.bin_out), 32'd0);
    chk("t1_range", 32'(bus.range_out), 32'hFFFE);
    chk("t1_count", 32'(bus.bin_count), 32'd1);

    // Bin 1 without renormalisation, minimum latency.
    do_start();
    feed_init(16'hC000);
    txn(16'h8000, 0, -1, 0, 1'b1, -1);
    chk("t2_bin", 32'(bus.bin_out), 32'd1);
    chk("t2_range", 32'(bus.range_out), 32'h8000);
    chk("t2_latency", 32'(last_edges), 32'd4);

    // Zero probability: split clamps to 1, fifteen renorm bits.
    do_start();
    feed_init(16'h0000);
    txn(16'h0000, 0, -1, 0, 1'b1, -1);
    chk("t3_range", 32'(bus.range_out), 32'h8000);
    chk("t3_bits", 32'(last_edges), 32'd19);

    // Backpressure in OUT for five cycles.
    txn(16'($urandom), 5, -1, 0, 1'b1, -1);

    // Three-cycle bit stall in the middle of renormalisation.
    do_start();
    feed_init(16'h0000);
    txn(16'h0000, 0, 5, 3, 1'b1, -1);
    chk("t5_range", 32'(bus.range_out), 32'h8000);

    // Reset while renormalising.
    do_start();
    feed_init(16'h0000);
    txn(16'h0000, 0, -1, 0, 1'b1, 5);
    reset = 1'b1;
    #1;
    chk("midrst_range", 32'(bus.range_out), 32'hFFFF);
    chk("midrst_bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("midrst_count", 32'(bus.bin_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    feed_init(16'($urandom));
    txn(16'($urandom), 0, -1, 0, 1'b1, -1);

    // Start while a bin is pending in OUT.
    txn(16'($urandom), 2, -1, 0, 1'b0, -1);
    do_start();
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_bin", 32'(bus.bin_valid), 32'd0);
    end
    feed_init(16'($urandom));
    txn(16'($urandom), 0, -1, 0, 1'b1, -1);

    // Randomised stream.
    do_start();
    feed_init(16'($urandom));
    for (int t = 0; t < 30; t++) begin
      txn(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 4),
          $urandom_range(0, 2), 1'b1, -1);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
